uart_program_loader: RTL and testbench

Boot-time loader sitting upstream of the core's program memory. It receives a framed program image over a UART RX line and assembles bytes into 32-bit little-endian words. Each word is written into the program BRAM through its write port (wr_addr, ram_in, byte_w_en). The core is held in reset until a complete image with a valid checksum has been written.

---
 rtl/uart_program_loader.sv | 198 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over 8N1 UART, writes 32-bit
// little-endian words into program BRAM and holds the core in reset until the image checks out.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for the sync byte
// LEN_LO   | next byte is the low byte of the word count
// LEN_HI   | next byte is the high byte; decides DATA / CHECK / ERROR
// DATA     | assembling payload bytes into words, one BRAM write per word
// CHECK    | next byte is the XOR checksum of the payload
// DONE     | image valid, core released; sync byte starts a reload
// ERROR    | bad length, framing error or checksum; sync byte retries
module uart_program_loader #(
  parameter int          CLKS_PER_BIT    = 868,
  parameter int          PMEM_ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       uart_rx,
  output logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr,
  output logic [31:0]                pmem_wr_data,
  output logic [3:0]                 pmem_byte_w_en,
  output logic                       cpu_rst,
  output logic                       load_done,
  output logic                       load_error
);

  localparam int             AW       = PMEM_ADDR_WIDTH;
  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]    CAPACITY = 17'(1) << AW;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR
  } ld_state_t;

  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  logic            rx_fall, rx_tick;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            byte_valid_d, frame_err_d;
  logic            byte_valid_q, frame_err_q;

  ld_state_t       st_q, st_d;
  logic [15:0]     len_q;
  logic [15:0]     len_new;
  logic [AW:0]     addr_q;
  logic [1:0]      idx_q;
  logic [31:0]     word_q;
  logic [7:0]      chk_q;
  logic            wr_q;
  logic            cpu_rst_q;
  logic            last_word;

  // rx_s3_q is the previous synchronised sample, used only for edge detection
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_cnt_q == '0);

  always_ff @(posedge sysclk) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_tick) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_d = (rx_state_q == RX_STOP) && rx_tick && rx_s2_q;
    frame_err_d  = (rx_state_q == RX_STOP) && rx_tick && !rx_s2_q;
  end

  // Idle keeps the half-bit count preloaded so the start check lands mid-bit
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      if (rx_state_q == RX_IDLE) begin
        rx_cnt_q <= HALF_BIT;
        rx_bit_q <= '0;
      end else if (rx_tick) begin
        rx_cnt_q <= FULL_BIT;
      end else begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end
      if (rx_state_q == RX_DATA && rx_tick) begin
        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 1'b1;
      end
    end
  end

  assign len_new   = {rx_shift_q, len_q[7:0]};
  assign last_word = (17'(addr_q) == (17'(len_q) - 17'd1));

  always_ff @(posedge sysclk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (frame_err_q && (st_q == ST_LEN_LO || st_q == ST_LEN_HI ||
                        st_q == ST_DATA   || st_q == ST_CHECK)) begin
      st_d = ST_ERROR;
    end else if (byte_valid_q) begin
      unique case (st_q)
        ST_IDLE:   if (rx_shift_q == SYNC_BYTE) st_d = ST_LEN_LO;
        ST_LEN_LO: st_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (17'(len_new) > CAPACITY) st_d = ST_ERROR;
          else if (len_new == 16'd0)   st_d = ST_CHECK;
          else                         st_d = ST_DATA;
        end
        ST_DATA:   if (idx_q == 2'd3 && last_word) st_d = ST_CHECK;
        ST_CHECK:  st_d = (rx_shift_q == chk_q) ? ST_DONE : ST_ERROR;
        ST_DONE,
        ST_ERROR:  if (rx_shift_q == SYNC_BYTE) st_d = ST_LEN_LO;
        default:   st_d = ST_IDLE;
      endcase
    end
  end

  // The write strobe lags the fourth byte by one cycle; the address steps after it
  always_ff @(posedge sysclk) begin
    if (rst) begin
      len_q     <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      wr_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      wr_q      <= 1'b0;
      cpu_rst_q <= (st_d != ST_DONE);
      if (wr_q) addr_q <= addr_q + 1'b1;
      if (byte_valid_q) begin
        unique case (st_q)
          ST_LEN_LO: len_q[7:0] <= rx_shift_q;
          ST_LEN_HI: begin
            len_q[15:8] <= rx_shift_q;
            addr_q      <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
          end
          ST_DATA: begin
            word_q[{idx_q, 3'b000} +: 8] <= rx_shift_q;
            chk_q <= chk_q ^ rx_shift_q;
            idx_q <= idx_q + 1'b1;
            if (idx_q == 2'd3) wr_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pmem_wr_addr   = addr_q[AW-1:0];
    pmem_wr_data   = word_q;
    pmem_byte_w_en = wr_q ? 4'b1111 : 4'b0000;
    cpu_rst        = cpu_rst_q;
    load_done      = (st_q == ST_DONE);
    load_error     = (st_q == ST_ERROR);
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench for uart_program_loader: frames are built in the bench, the
// expected BRAM writes and final status are derived from the frame contents.
module tb_uart_program_loader;

  localparam int CPB = 4;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          sysclk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic [AW-1:0] pmem_wr_addr;
  logic [31:0]   pmem_wr_data;
  logic [3:0]    pmem_byte_w_en;
  logic          cpu_rst;
  logic          load_done;
  logic          load_error;

  int checks   = 0;
  int failures = 0;
  int bad_en   = 0;
  int inv_err  = 0;

  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] fw [0:CAP-1];

  uart_program_loader #(
    .CLKS_PER_BIT    (CPB),
    .PMEM_ADDR_WIDTH (AW),
    .SYNC_BYTE       (8'hA5)
  ) dut (
    .sysclk         (sysclk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .pmem_wr_addr   (pmem_wr_addr),
    .pmem_wr_data   (pmem_wr_data),
    .pmem_byte_w_en (pmem_byte_w_en),
    .cpu_rst        (cpu_rst),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // The core may run exactly when the loader reports a good image
  always @(negedge sysclk) begin
    if (!rst) begin
      if (pmem_byte_w_en != 4'b0000) begin
        if (pmem_byte_w_en != 4'b1111) bad_en++;
        got_addr.push_back(int'(pmem_wr_addr));
        got_data.push_back(pmem_wr_data);
      end
      if (cpu_rst === load_done) inv_err++;
      if (load_done && load_error) inv_err++;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    idle_cycles(CPB);
  endtask

  task automatic send_bits(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bits(b);
    send_bit(stop_bit);
    if (!stop_bit) send_bit(1'b1);
    idle_cycles($urandom_range(0, 5));
  endtask

  task automatic send_chk(input logic [7:0] b, input logic exp_rst);
    send_bits(b);
    check_val("cpu_rst_before_chk", {31'd0, cpu_rst}, 32'd1);
    send_bit(1'b1);
    idle_cycles(CPB);
    check_val("cpu_rst_after_chk", {31'd0, cpu_rst}, {31'd0, exp_rst});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check_val({tag, "_done"},    {31'd0, load_done}, 32'd0);
    check_val({tag, "_error"},   {31'd0, load_error}, 32'd0);
    check_val({tag, "_wen"},     {28'd0, pmem_byte_w_en}, 32'd0);
    check_val({tag, "_addr"},    {30'd0, pmem_wr_addr}, 32'd0);
    check_val({tag, "_data"},    pmem_wr_data, 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n);
    check_val({tag, "_nwrites"}, got_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_addr.size()) begin
        check_val({tag, "_waddr"}, got_addr[i], i);
        check_val({tag, "_wdata"}, got_data[i], fw[i]);
      end
    end
  endtask

  task automatic check_status(input string tag, input logic done);
    check_val({tag, "_done"},    {31'd0, load_done},  {31'd0, done});
    check_val({tag, "_error"},   {31'd0, load_error}, {31'd0, !done});
    check_val({tag, "_cpu_rst"}, {31'd0, cpu_rst},    {31'd0, !done});
  endtask

  // Sends a full frame carrying fw[0..n-1]; expectations follow from the frame alone
  task automatic run_frame(input string tag, input int n, input bit corrupt, input bit glitch = 1'b0);
    logic [7:0]  x;
    logic [15:0] len;
    x   = 8'h00;
    len = 16'(n);
    got_addr.delete();
    got_data.delete();
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    if (n > CAP) begin
      idle_cycles(2 * CPB);
      check_writes(tag, 0);
      check_status(tag, 1'b0);
      return;
    end
    if (glitch) begin
      uart_rx = 1'b0;
      idle_cycles(1);
      uart_rx = 1'b1;
      idle_cycles(3 * CPB);
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = fw[w][8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
    send_chk(corrupt ? (x ^ 8'h01) : x, corrupt);
    idle_cycles(2);
    check_writes(tag, n);
    check_status(tag, !corrupt);
  endtask

  task automatic load_example();
    fw[0] = 32'h0000_0013;
    fw[1] = 32'h0010_0093;
  endtask

  initial begin
    uart_rx = 1'b1;
    rst     = 1'b1;
    idle_cycles(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_cycles(4);

    load_example();
    run_frame("valid", 2, 1'b0);

    run_frame("badchk", 2, 1'b1);
    run_frame("retry", 2, 1'b0);

    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(2);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check_val("garbage_done", {31'd0, load_done}, 32'd0);
    run_frame("after_garbage", 2, 1'b0);

    got_addr.delete();
    got_data.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00, 1'b0);
    idle_cycles(2);
    check_val("ferr_error", {31'd0, load_error}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h80);
    idle_cycles(2 * CPB);
    check_writes("ferr", 0);
    check_status("ferr", 1'b0);

    run_frame("n0", 0, 1'b0);
    run_frame("n5", 5, 1'b0);
    run_frame("n256", 256, 1'b0);
    for (int i = 0; i < CAP; i++) fw[i] = $urandom;
    run_frame("n4", 4, 1'b0);

    load_example();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    rst = 1'b1;
    idle_cycles(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle_cycles(2);
    run_frame("after_rst", 2, 1'b0);

    fw[0] = 32'hDEAD_BEEF;
    run_frame("glitch", 1, 1'b0, 1'b1);

    for (int it = 0; it < 10; it++) begin
      int n;
      int ng;
      bit corrupt;
      n       = $urandom_range(0, CAP + 1);
      corrupt = ($urandom_range(0, 3) == 0);
      ng      = $urandom_range(0, 2);
      for (int i = 0; i < CAP; i++) fw[i] = $urandom;
      for (int g = 0; g < ng; g++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
      end
      run_frame("rand", n, corrupt);
    end

    check_val("wen_pattern", bad_en, 0);
    check_val("cpu_rst_vs_status", inv_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
